// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle RV32I control FSM with memory watchdog and instret counter
module multicycle_sequencer #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req_valid_o,
    input  logic             ifu_req_ready_i,
    input  logic             ifu_resp_valid_i,
    output logic             lsu_req_valid_o,
    output logic             lsu_req_we_o,
    input  logic             lsu_req_ready_i,
    input  logic             lsu_resp_valid_i,
    input  logic             mem_read_i,
    input  logic             mem_write_i,
    input  logic             reg_wr_i,
    input  logic             halt_i,
    output logic             ir_we_o,
    output logic             mdr_we_o,
    output logic             pc_we_o,
    output logic             rf_we_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic             err_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_FWAIT, S_EXEC, S_MEM, S_MWAIT, S_WB, S_HALT, S_ERR
    } state_t;

    state_t          state, state_next;
    logic [WD_W-1:0] wdog;
    logic            wd_expired;
    logic            in_phase;
    logic            phase_entry;

    // Expired means this is the last allowed cycle of the phase; a handshake now still wins.
    assign wd_expired  = (wdog >= WD_W'(TIMEOUT_CYC - 1));
    assign in_phase    = (state == S_FETCH) || (state == S_FWAIT) ||
                         (state == S_MEM)   || (state == S_MWAIT);
    assign phase_entry = ((state_next == S_FETCH) && (state != S_FETCH)) ||
                         ((state_next == S_MEM)   && (state != S_MEM));

    assign ifu_req_valid_o = (state == S_FETCH);
    assign lsu_req_valid_o = (state == S_MEM);
    assign lsu_req_we_o    = (state == S_MEM) && mem_write_i;
    assign busy_o          = (state != S_IDLE) && (state != S_HALT) && (state != S_ERR);
    assign halted_o        = (state == S_HALT);
    assign err_o           = (state == S_ERR);

    always_comb begin
        state_next = state;
        ir_we_o    = 1'b0;
        mdr_we_o   = 1'b0;
        pc_we_o    = 1'b0;
        rf_we_o    = 1'b0;
        case (state)
            S_IDLE:  state_next = S_FETCH;
            S_FETCH: begin
                if (ifu_req_ready_i)  state_next = S_FETCH == S_FETCH ? S_FWAIT : S_FETCH;
                else if (wd_expired)  state_next = S_ERR;
            end
            S_FWAIT: begin
                if (ifu_resp_valid_i) begin
                    ir_we_o    = 1'b1;
                    state_next = S_EXEC;
                end else if (wd_expired) begin
                    state_next = S_ERR;
                end
            end
            S_EXEC: begin
                if (halt_i)                          state_next = S_HALT;
                else if (mem_read_i && mem_write_i)  state_next = S_ERR;
                else if (mem_read_i || mem_write_i)  state_next = S_MEM;
                else                                 state_next = S_WB;
            end
            S_MEM: begin
                if (lsu_req_ready_i)  state_next = S_MWAIT;
                else if (wd_expired)  state_next = S_ERR;
            end
            S_MWAIT: begin
                if (lsu_resp_valid_i) begin
                    mdr_we_o   = mem_read_i;
                    state_next = S_WB;
                end else if (wd_expired) begin
                    state_next = S_ERR;
                end
            end
            S_WB: begin
                pc_we_o    = 1'b1;
                rf_we_o    = reg_wr_i && !mem_write_i;
                state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_ERR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wdog      <= '0;
            instret_o <= '0;
        end else begin
            state <= state_next;
            if (phase_entry)   wdog <= '0;
            else if (in_phase) wdog <= wdog + WD_W'(1);
            else               wdog <= '0;
            if (state == S_WB) instret_o <= instret_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ifu_ready, ifu_resp, lsu_ready, lsu_resp, mem_read, mem_write, reg_wr, halt;
    logic ifu_req, lsu_req, lsu_we, ir_we, mdr_we, pc_we, rf_we, busy, halted, err;
    logic [31:0] instret;

    logic w_rst, w_ifu_ready, w_ifu_resp, w_zero;
    logic w_ifu_req, w_lsu_req, w_lsu_we, w_ir_we, w_mdr_we, w_pc_we, w_rf_we;
    logic w_busy, w_halted, w_err;
    logic [31:0] w_instret;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_sequencer dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid_o(ifu_req), .ifu_req_ready_i(ifu_ready), .ifu_resp_valid_i(ifu_resp),
        .lsu_req_valid_o(lsu_req), .lsu_req_we_o(lsu_we), .lsu_req_ready_i(lsu_ready),
        .lsu_resp_valid_i(lsu_resp), .mem_read_i(mem_read), .mem_write_i(mem_write),
        .reg_wr_i(reg_wr), .halt_i(halt), .ir_we_o(ir_we), .mdr_we_o(mdr_we),
        .pc_we_o(pc_we), .rf_we_o(rf_we), .busy_o(busy), .halted_o(halted),
        .err_o(err), .instret_o(instret)
    );

    multicycle_sequencer #(.TIMEOUT_CYC(4), .CNT_W(32)) dut_wd (
        .clk(clk), .rst(w_rst),
        .ifu_req_valid_o(w_ifu_req), .ifu_req_ready_i(w_ifu_ready), .ifu_resp_valid_i(w_ifu_resp),
        .lsu_req_valid_o(w_lsu_req), .lsu_req_we_o(w_lsu_we), .lsu_req_ready_i(w_zero),
        .lsu_resp_valid_i(w_zero), .mem_read_i(w_zero), .mem_write_i(w_zero),
        .reg_wr_i(w_zero), .halt_i(w_zero), .ir_we_o(w_ir_we), .mdr_we_o(w_mdr_we),
        .pc_we_o(w_pc_we), .rf_we_o(w_rf_we), .busy_o(w_busy), .halted_o(w_halted),
        .err_o(w_err), .instret_o(w_instret)
    );

    // Bit order: ifu_req lsu_req lsu_we ir_we mdr_we pc_we rf_we busy halted err
    logic [9:0] obs, obs_w;
    assign obs   = {ifu_req, lsu_req, lsu_we, ir_we, mdr_we, pc_we, rf_we, busy, halted, err};
    assign obs_w = {w_ifu_req, w_lsu_req, w_lsu_we, w_ir_we, w_mdr_we, w_pc_we, w_rf_we,
                    w_busy, w_halted, w_err};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs for the current cycle are already driven; settle, compare, advance one clock.
    task automatic cyc_check(input string tag, input logic [9:0] exp, input bit wd);
        #1;
        check(tag, 32'(wd ? obs_w : obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_ready = 0; ifu_resp = 0; lsu_ready = 0; lsu_resp = 0;
        mem_read = 0; mem_write = 0; reg_wr = 0; halt = 0;
    endtask

    initial begin
        rst = 1; w_rst = 1; w_ifu_ready = 0; w_ifu_resp = 0; w_zero = 0;
        clear_inputs();
        @(posedge clk); #1;
        cyc_check("reset_outputs", 10'b0000000000, 0);
        check("reset_instret", instret, 32'd0);
        check("reset_outputs_wd", 32'(obs_w), 32'd0);

        rst = 0;
        cyc_check("idle", 10'b0000000000, 0);

        // addi: FETCH c1, FWAIT c2, EXEC c3, WB c4, FETCH c5
        ifu_ready = 1;               cyc_check("alu_fetch", 10'b1000000100, 0);
        ifu_ready = 0; ifu_resp = 1; cyc_check("alu_fwait_irwe", 10'b0001000100, 0);
        ifu_resp = 0; reg_wr = 1;    cyc_check("alu_exec", 10'b0000000100, 0);
        check("alu_instret_before_wb", instret, 32'd0);
        cyc_check("alu_wb", 10'b0000011100, 0);
        check("alu_instret", instret, 32'd1);
        reg_wr = 0;

        // load with lsu_req_ready low for 3 cycles and response 2 cycles after accept
        ifu_ready = 1;               cyc_check("ld_fetch", 10'b1000000100, 0);
        ifu_ready = 0; ifu_resp = 1; cyc_check("ld_fwait", 10'b0001000100, 0);
        ifu_resp = 0; mem_read = 1; reg_wr = 1;
        cyc_check("ld_exec", 10'b0000000100, 0);
        cyc_check("ld_mem1", 10'b0100000100, 0);
        lsu_resp = 1;                cyc_check("ld_mem2_resp_ignored", 10'b0100000100, 0);
        lsu_resp = 0;                cyc_check("ld_mem3", 10'b0100000100, 0);
        lsu_ready = 1;               cyc_check("ld_mem4_accept", 10'b0100000100, 0);
        lsu_ready = 0;               cyc_check("ld_mwait", 10'b0000000100, 0);
        lsu_resp = 1;                cyc_check("ld_mdrwe", 10'b0000100100, 0);
        lsu_resp = 0;                cyc_check("ld_wb", 10'b0000011100, 0);
        check("ld_instret", instret, 32'd2);
        mem_read = 0; reg_wr = 0;

        // store: reg_wr set but WB must not write the register file
        ifu_ready = 1;               cyc_check("st_fetch", 10'b1000000100, 0);
        ifu_ready = 0; ifu_resp = 1; cyc_check("st_fwait", 10'b0001000100, 0);
        ifu_resp = 0; mem_write = 1; reg_wr = 1;
        cyc_check("st_exec", 10'b0000000100, 0);
        lsu_ready = 1;               cyc_check("st_mem_we", 10'b0110000100, 0);
        lsu_ready = 0; lsu_resp = 1; cyc_check("st_mwait_no_mdr", 10'b0000000100, 0);
        lsu_resp = 0;                cyc_check("st_wb_no_rf", 10'b0000010100, 0);
        check("st_instret", instret, 32'd3);
        mem_write = 0; reg_wr = 0;

        // ebreak in EXEC
        ifu_ready = 1;               cyc_check("halt_fetch", 10'b1000000100, 0);
        ifu_ready = 0; ifu_resp = 1; cyc_check("halt_fwait", 10'b0001000100, 0);
        ifu_resp = 0; halt = 1; reg_wr = 1;
        cyc_check("halt_exec", 10'b0000000100, 0);
        cyc_check("halted", 10'b0000000010, 0);
        ifu_ready = 1; ifu_resp = 1; cyc_check("halted_sticky", 10'b0000000010, 0);
        check("halt_instret", instret, 32'd3);
        clear_inputs();

        // reset from HALT, then reset again while in MWAIT with a response pending
        rst = 1;                     cyc_check("rst_from_halt", 10'b0000000000, 0);
        rst = 0;                     cyc_check("idle2", 10'b0000000000, 0);
        ifu_ready = 1;               cyc_check("rm_fetch", 10'b1000000100, 0);
        ifu_ready = 0; ifu_resp = 1; cyc_check("rm_fwait", 10'b0001000100, 0);
        ifu_resp = 0; mem_read = 1;  cyc_check("rm_exec", 10'b0000000100, 0);
        lsu_ready = 1;               cyc_check("rm_mem", 10'b0100000100, 0);
        lsu_ready = 0; lsu_resp = 1; rst = 1;
        cyc_check("rm_rst_no_mdrwe", 10'b0000000000, 0);
        check("rm_instret_cleared", instret, 32'd0);
        rst = 0;                     cyc_check("rm_idle_resp_ignored", 10'b0000000000, 0);
        lsu_resp = 0; mem_read = 0;  cyc_check("rm_fetch_hold", 10'b1000000100, 0);
        cyc_check("rm_fetch_hold2", 10'b1000000100, 0);

        // mem_read and mem_write together is illegal
        ifu_ready = 1;               cyc_check("bad_fetch", 10'b1000000100, 0);
        ifu_ready = 0; ifu_resp = 1; cyc_check("bad_fwait", 10'b0001000100, 0);
        ifu_resp = 0; mem_read = 1; mem_write = 1;
        cyc_check("bad_exec", 10'b0000000100, 0);
        cyc_check("bad_err", 10'b0000000001, 0);
        clear_inputs();
        cyc_check("bad_err_sticky", 10'b0000000001, 0);

        // watchdog, TIMEOUT_CYC=4: handshakes on the last allowed cycle still win
        w_rst = 0;                   cyc_check("wd_idle", 10'b0000000000, 1);
        cyc_check("wd_fetch0", 10'b1000000100, 1);
        cyc_check("wd_fetch1", 10'b1000000100, 1);
        cyc_check("wd_fetch2", 10'b1000000100, 1);
        w_ifu_ready = 1;             cyc_check("wd_fetch3_accept", 10'b1000000100, 1);
        w_ifu_ready = 0; w_ifu_resp = 1;
        cyc_check("wd_fwait_resp_wins", 10'b0001000100, 1);
        w_ifu_resp = 0;              cyc_check("wd_exec", 10'b0000000100, 1);
        cyc_check("wd_wb", 10'b0000010100, 1);
        check("wd_instret", w_instret, 32'd1);

        // response never arrives: 4 cycles in the phase, then ERR
        w_ifu_ready = 1;             cyc_check("to_fetch", 10'b1000000100, 1);
        w_ifu_ready = 0;             cyc_check("to_fwait1", 10'b0000000100, 1);
        cyc_check("to_fwait2", 10'b0000000100, 1);
        cyc_check("to_fwait3", 10'b0000000100, 1);
        w_ifu_resp = 1;              cyc_check("to_err", 10'b0000000001, 1);
        cyc_check("to_err_sticky", 10'b0000000001, 1);
        w_ifu_resp = 0; w_rst = 1;   cyc_check("to_rst_clears", 10'b0000000000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
